// File: rtl/uart_pkg.sv
// Shared definitions for the UART link (receiver and transmitter).
// Holds the FSM state encoding, default frame parameters and a counter-width helper.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_CLKS_PER_BIT = 868;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for bringing an asynchronous level into the clk domain.
// Both stages reset to RESET_VAL so the output shows a known level straight out of reset.
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so both stages sample
  // the pre-edge values; blocking here would collapse the chain into one flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: synchronizes rx, finds the start bit, samples each bit at
// mid-bit and presents the byte with a one-cycle valid (or frame-error) strobe.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 i_reset,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_data_valid,
  output logic                 o_frame_error,
  output logic                 o_busy
);

  localparam int CNT_W = cnt_width(CLKS_PER_BIT);
  localparam int IDX_W = cnt_width(DATA_BITS);

  localparam logic [CNT_W-1:0] MID_C    = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic rx_s;

  // NOTE: the synchronizer resets to 1 (line idle) rather than 0, otherwise
  // leaving reset would look like a falling edge and start a bogus frame.
  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clk (clk),
    .rst (i_reset),
    .d_i (i_rx),
    .q_o (rx_s)
  );

  uart_state_t          state_q, state_d;
  logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  // NOTE: every *_d gets a default before the case so no path leaves one
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        if (!rx_s) begin
          state_d = START;
        end
      end

      START: begin
        // Confirming the start bit at its midpoint aligns every later sample to mid-bit.
        if (clk_cnt_q == MID_C) begin
          clk_cnt_d = '0;
          if (!rx_s) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      DATA: begin
        if (clk_cnt_q == LAST_C) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
          if (bit_idx_q == IDX_LAST) begin
            state_d   = STOP;
            bit_idx_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      STOP: begin
        // Leaving at mid-stop keeps a back-to-back start bit from being missed.
        if (clk_cnt_q == LAST_C) begin
          clk_cnt_d = '0;
          state_d   = IDLE;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_data        = data_q;
  assign o_data_valid  = valid_q;
  assign o_frame_error = ferr_q;
  assign o_busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at CLKS_PER_BIT=8: frames are driven bit by bit
// from the bench clock and the strobes are collected by a negedge monitor.
module tb_uart_receiver;

  localparam int CPB = 8;
  localparam int DB  = 8;

  logic          clk;
  logic          i_reset;
  logic          i_rx;
  logic [DB-1:0] o_data;
  logic          o_data_valid;
  logic          o_frame_error;
  logic          o_busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Written only by the monitor; tests take snapshots and compare deltas.
  int          n_valid   = 0;
  int          n_ferr    = 0;
  int          n_overlap = 0;
  logic [7:0]  got_q[$];

  uart_receiver #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (DB)
  ) dut (
    .clk           (clk),
    .i_reset       (i_reset),
    .i_rx          (i_rx),
    .o_data        (o_data),
    .o_data_valid  (o_data_valid),
    .o_frame_error (o_frame_error),
    .o_busy        (o_busy)
  );

  initial clk = 1'b0;
  always #1 clk = ~clk;

  always @(negedge clk) begin
    if (!i_reset) begin
      if (o_data_valid) begin
        n_valid++;
        got_q.push_back(o_data);
      end
      if (o_frame_error) n_ferr++;
      if (o_data_valid && o_frame_error) n_overlap++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic hold_bit(input logic v);
    i_rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    hold_bit(1'b0);
    for (int i = 0; i < DB; i++) hold_bit(b[i]);
    hold_bit(stop_bit);
    i_rx = 1'b1;
  endtask

  task automatic idle(input int cycles);
    i_rx = 1'b1;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v0, e0, g0;

    // Reset with the line idle.
    i_reset = 1'b1;
    i_rx    = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_data",  32'(o_data), 32'h00);
    check("rst_valid", 32'(o_data_valid), 32'h0);
    check("rst_ferr",  32'(o_frame_error), 32'h0);
    check("rst_busy",  32'(o_busy), 32'h0);
    i_reset = 1'b0;
    idle(10);
    check("post_rst_busy", 32'(o_busy), 32'h0);

    // Two frames back-to-back with no idle between them.
    v0 = n_valid; e0 = n_ferr; g0 = got_q.size();
    send_frame(8'hF0, 1'b1);
    send_frame(8'hA5, 1'b1);
    idle(12);
    check("b2b_count", 32'(n_valid - v0), 32'd2);
    check("b2b_ferr",  32'(n_ferr - e0), 32'd0);
    if (got_q.size() >= g0 + 2) begin
      check("b2b_byte0", 32'(got_q[g0]),     32'hF0);
      check("b2b_byte1", 32'(got_q[g0 + 1]), 32'hA5);
    end
    check("b2b_data", 32'(o_data), 32'hA5);

    // Three-cycle low glitch: enters START, then rejected at mid-bit.
    v0 = n_valid; e0 = n_ferr;
    i_rx = 1'b0;
    repeat (3) @(negedge clk);
    check("glitch_busy_hi", 32'(o_busy), 32'h1);
    i_rx = 1'b1;
    repeat (7) @(negedge clk);
    check("glitch_busy_lo", 32'(o_busy), 32'h0);
    idle(10);
    check("glitch_valid", 32'(n_valid - v0), 32'd0);
    check("glitch_ferr",  32'(n_ferr - e0), 32'd0);

    // Stop bit forced low: error strobe only, byte discarded.
    v0 = n_valid; e0 = n_ferr;
    send_frame(8'h3C, 1'b0);
    idle(20);
    check("ferr_count", 32'(n_ferr - e0), 32'd1);
    check("ferr_valid", 32'(n_valid - v0), 32'd0);
    check("ferr_data",  32'(o_data), 32'hA5);
    check("ferr_busy",  32'(o_busy), 32'h0);

    // Reset asserted midway through data bit 4 of 0x55.
    v0 = n_valid; e0 = n_ferr;
    hold_bit(1'b0);
    for (int i = 0; i < 4; i++) hold_bit(8'h55 >> i);
    i_rx = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    check("midrst_data",  32'(o_data), 32'h00);
    check("midrst_valid", 32'(o_data_valid), 32'h0);
    check("midrst_ferr",  32'(o_frame_error), 32'h0);
    check("midrst_busy",  32'(o_busy), 32'h0);
    repeat (4) @(negedge clk);
    i_reset = 1'b0;
    idle(20);
    check("abort_valid", 32'(n_valid - v0), 32'd0);
    g0 = got_q.size();
    send_frame(8'h81, 1'b1);
    idle(12);
    check("after_rst_count", 32'(n_valid - v0), 32'd1);
    check("after_rst_ferr",  32'(n_ferr - e0), 32'd0);
    check("after_rst_data",  32'(o_data), 32'h81);

    // All-zero then all-one data bits.
    v0 = n_valid; g0 = got_q.size();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(12);
    check("ext_count", 32'(n_valid - v0), 32'd2);
    if (got_q.size() >= g0 + 2) begin
      check("ext_byte0", 32'(got_q[g0]),     32'h00);
      check("ext_byte1", 32'(got_q[g0 + 1]), 32'hFF);
    end

    check("no_overlap", 32'(n_overlap), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
